// File: rtl/atari7800_pkg.sv
// Shared Atari 7800 core definitions: high-score save upload FSM states,
// default selector/timing constants and small address helpers.
package atari7800_pkg;

  localparam int unsigned  HSC_IOCTL_AW   = 25;
  localparam logic [7:0]   HSC_SAVE_INDEX = 8'd2;
  localparam logic [23:0]  HSC_QUIET_CYC  = 24'd7_143_000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2
  } hsc_rd_state_e;

  // True when a host byte address lies beyond a save image of 2**aw bytes.
  function automatic logic addr_oob(input logic [HSC_IOCTL_AW-1:0] addr,
                                    input int unsigned aw);
    return (addr >> aw) != 25'd0;
  endfunction

endpackage

// File: rtl/hsc_save_upload_if.sv
// Host ioctl upload bus: the host (master) strobes byte reads, the save
// block (slave) returns the byte on ioctl_din.
interface hsc_ioctl_if;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;

  modport master (
    output ioctl_upload,
    output ioctl_index,
    output ioctl_rd,
    output ioctl_addr,
    input  ioctl_din
  );

  modport slave (
    input  ioctl_upload,
    input  ioctl_index,
    input  ioctl_rd,
    input  ioctl_addr,
    output ioctl_din
  );
endinterface

// File: rtl/hsc_save_upload_dirty_tracker.sv
// Tracks unsaved console writes to the save RAM and raises a level request
// to the HPS after a quiet period or when the OSD opens.
module save_dirty_tracker
  import atari7800_pkg::*;
#(
  parameter logic [23:0] QUIET_CYC = HSC_QUIET_CYC
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic cpu_wr,
  input  logic osd_status,
  input  logic sel_rise,
  input  logic sel_fall,
  output logic save_req
);

  logic        dirty_r;
  logic        wr_in_sess_r;
  logic [23:0] quiet_cnt_r;
  logic        quiet_seen_r;
  logic        osd_d_r;
  logic        save_req_r;
  logic        quiet_hit_s;
  logic        osd_rise_s;
  logic        set_req_s;

  // Request triggers: first cycle at saturation, or OSD opening; a write wins.
  always_comb begin
    quiet_hit_s = 1'b0;
    osd_rise_s  = 1'b0;
    set_req_s   = 1'b0;
    quiet_hit_s = (quiet_cnt_r == QUIET_CYC) && !quiet_seen_r;
    osd_rise_s  = osd_status && !osd_d_r;
    if (dirty_r && !cpu_wr) begin
      set_req_s = quiet_hit_s || osd_rise_s;
    end else begin
      set_req_s = 1'b0;
    end
  end

  // Dirty flag and the "written during this session" marker.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dirty_r      <= 1'b0;
      wr_in_sess_r <= 1'b0;
    end else begin
      if (sel_rise) begin
        wr_in_sess_r <= cpu_wr;
      end else begin
        wr_in_sess_r <= wr_in_sess_r | cpu_wr;
      end
      if (cpu_wr) begin
        dirty_r <= 1'b1;
      end else if (sel_fall && !wr_in_sess_r) begin
        dirty_r <= 1'b0;
      end else begin
        dirty_r <= dirty_r;
      end
    end
  end

  // Saturating quiet counter plus edge-detect history.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      quiet_cnt_r  <= 24'd0;
      quiet_seen_r <= 1'b0;
      osd_d_r      <= 1'b0;
    end else begin
      if (cpu_wr) begin
        quiet_cnt_r <= 24'd0;
      end else if (dirty_r && (quiet_cnt_r != QUIET_CYC)) begin
        quiet_cnt_r <= quiet_cnt_r + 24'd1;
      end else begin
        quiet_cnt_r <= quiet_cnt_r;
      end
      quiet_seen_r <= (quiet_cnt_r == QUIET_CYC);
      osd_d_r      <= osd_status;
    end
  end

  // Save request level; a new upload session acknowledges it.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      save_req_r <= 1'b0;
    end else if (set_req_s) begin
      save_req_r <= 1'b1;
    end else if (sel_rise) begin
      save_req_r <= 1'b0;
    end else begin
      save_req_r <= save_req_r;
    end
  end

  assign save_req = save_req_r;

endmodule

// File: rtl/hsc_save_upload.sv
// High-score / SaveKey image upload: serves host byte reads from the save
// RAM read port and signals the HPS when the image needs saving.
module hsc_save_upload
  import atari7800_pkg::*;
#(
  parameter int unsigned  ADDR_W     = 11,
  parameter logic [7:0]   SAVE_INDEX = HSC_SAVE_INDEX,
  parameter logic [23:0]  QUIET_CYC  = HSC_QUIET_CYC
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  hsc_ioctl_if.slave        io,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_q,
  input  logic              cpu_wr,
  input  logic              osd_status,
  output logic              save_req,
  output logic              busy,
  output logic              rd_err
);

  hsc_rd_state_e     state_r;
  logic [24:0]       addr_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic              mem_rd_r;
  logic              busy_r;
  logic [7:0]        din_r;
  logic              rd_err_r;
  logic              sel_d_r;
  logic              sel_s;
  logic              sel_rise_s;
  logic              sel_fall_s;
  logic              rd_go_s;
  logic              rd_drop_s;

  // Session select, its edges, and accept/drop decisions for host strobes.
  always_comb begin
    sel_s      = 1'b0;
    sel_rise_s = 1'b0;
    sel_fall_s = 1'b0;
    rd_go_s    = 1'b0;
    rd_drop_s  = 1'b0;
    sel_s      = io.ioctl_upload && (io.ioctl_index == SAVE_INDEX);
    sel_rise_s = sel_s && !sel_d_r;
    sel_fall_s = !sel_s && sel_d_r;
    if (sel_s && io.ioctl_rd) begin
      rd_go_s   = (state_r == ST_IDLE);
      rd_drop_s = (state_r != ST_IDLE);
    end else begin
      rd_go_s   = 1'b0;
      rd_drop_s = 1'b0;
    end
  end

  // Read sequencer: issue one RAM read, wait out its latency, load the byte.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      addr_r     <= 25'd0;
      mem_addr_r <= {ADDR_W{1'b0}};
      mem_rd_r   <= 1'b0;
      busy_r     <= 1'b0;
      din_r      <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (rd_go_s) begin
            addr_r     <= io.ioctl_addr;
            mem_addr_r <= io.ioctl_addr[ADDR_W-1:0];
            mem_rd_r   <= 1'b1;
            busy_r     <= 1'b1;
            state_r    <= ST_FETCH;
          end else begin
            mem_rd_r   <= 1'b0;
            busy_r     <= 1'b0;
          end
        end
        ST_FETCH: begin
          mem_rd_r <= 1'b0;
          state_r  <= ST_WAIT;
        end
        ST_WAIT: begin
          din_r   <= addr_oob(addr_r, ADDR_W) ? 8'hFF : mem_q;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          mem_rd_r <= 1'b0;
          busy_r   <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky dropped-strobe flag, cleared when a new session opens.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rd_err_r <= 1'b0;
      sel_d_r  <= 1'b0;
    end else begin
      sel_d_r <= sel_s;
      if (rd_drop_s) begin
        rd_err_r <= 1'b1;
      end else if (sel_rise_s) begin
        rd_err_r <= 1'b0;
      end else begin
        rd_err_r <= rd_err_r;
      end
    end
  end

  save_dirty_tracker #(
    .QUIET_CYC (QUIET_CYC)
  ) u_dirty (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .cpu_wr     (cpu_wr),
    .osd_status (osd_status),
    .sel_rise   (sel_rise_s),
    .sel_fall   (sel_fall_s),
    .save_req   (save_req)
  );

  assign io.ioctl_din = din_r;
  assign mem_addr     = mem_addr_r;
  assign mem_rd       = mem_rd_r;
  assign busy         = busy_r;
  assign rd_err       = rd_err_r;

endmodule

// File: tb/tb_hsc_save_upload.sv
// Scoreboard bench for hsc_save_upload: reads push expected bytes, a monitor
// pops them when busy falls; level outputs are checked inline.
module tb_hsc_save_upload;
  localparam int unsigned Q = 20;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_q = 8'h00;
  logic        cpu_wr = 1'b0;
  logic        osd_status = 1'b0;
  logic        save_req;
  logic        busy;
  logic        rd_err;

  hsc_ioctl_if host ();

  hsc_save_upload #(
    .ADDR_W     (11),
    .SAVE_INDEX (8'd2),
    .QUIET_CYC  (24'd20)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .io         (host),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_q      (mem_q),
    .cpu_wr     (cpu_wr),
    .osd_status (osd_status),
    .save_req   (save_req),
    .busy       (busy),
    .rd_err     (rd_err)
  );

  always #5 clk_sys = ~clk_sys;

  logic [7:0] ram [0:2047];
  initial begin
    for (int i = 0; i < 2048; i++) ram[i] = 8'(i) ^ 8'h5A;
    ram[5] = 8'hA7;
  end
  always @(posedge clk_sys) if (mem_rd) mem_q <= ram[mem_addr];

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [7:0] exp_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: each completed read (busy falling) must match the scoreboard head.
  initial begin
    logic busy_q;
    logic [7:0] e;
    busy_q = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        busy_q = 1'b0;
      end else begin
        if (busy_q && !busy) begin
          if (exp_q.size() == 0) begin
            chk("sb_unexpected_load", 32'(host.ioctl_din), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("sb_din", 32'(host.ioctl_din), 32'(e));
          end
        end
        busy_q = busy;
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic sess_start();
    host.ioctl_upload = 1'b1;
    host.ioctl_index  = 8'd2;
    tick();
  endtask

  task automatic sess_end();
    host.ioctl_upload = 1'b0;
    tick();
  endtask

  task automatic do_read(input logic [24:0] a, input logic [7:0] exp, input string nm);
    logic [10:0] lo;
    lo = a[10:0];
    host.ioctl_rd   = 1'b1;
    host.ioctl_addr = a;
    exp_q.push_back(exp);
    tick();
    host.ioctl_rd = 1'b0;
    chk({nm, "_mem_rd"}, 32'(mem_rd), 32'd1);
    chk({nm, "_mem_addr"}, 32'(mem_addr), 32'(lo));
    tick();
    chk({nm, "_busy2"}, 32'({busy, mem_rd}), 32'b10);
    tick();
    chk({nm, "_din"}, 32'({busy, host.ioctl_din}), 32'(exp));
    tick();
  endtask

  task automatic wr_pulse();
    cpu_wr = 1'b1;
    tick();
    cpu_wr = 1'b0;
  endtask

  initial begin
    logic seen;
    host.ioctl_upload = 1'b0;
    host.ioctl_index  = 8'd0;
    host.ioctl_rd     = 1'b0;
    host.ioctl_addr   = 25'd0;
    repeat (3) tick();
    chk("reset_outs", 32'({host.ioctl_din, mem_rd, busy, rd_err, save_req}), 32'd0);
    chk("reset_mem_addr", 32'(mem_addr), 32'd0);
    reset_n = 1'b1;
    tick();

    // Strobes outside a matching session are ignored.
    host.ioctl_upload = 1'b1; host.ioctl_index = 8'd3;
    host.ioctl_rd = 1'b1; host.ioctl_addr = 25'h005;
    tick();
    host.ioctl_rd = 1'b0;
    chk("unsel_index", 32'({mem_rd, busy}), 32'd0);
    host.ioctl_upload = 1'b0; host.ioctl_index = 8'd2; host.ioctl_rd = 1'b1;
    tick();
    host.ioctl_rd = 1'b0;
    chk("unsel_upload", 32'({mem_rd, busy}), 32'd0);
    tick();

    sess_start();
    do_read(25'h005, 8'hA7, "rd005");
    do_read(25'h7FF, 8'hA5, "rd7ff");
    do_read(25'h123, 8'h79, "rd123");
    do_read(25'h800, 8'hFF, "rd800");
    do_read(25'h1000005, 8'hFF, "rdhigh");
    chk("no_err_yet", 32'(rd_err), 32'd0);

    // Back-to-back strobe: second one dropped, sticky error raised.
    host.ioctl_rd = 1'b1; host.ioctl_addr = 25'h7FF; exp_q.push_back(8'hA5);
    tick();
    host.ioctl_addr = 25'h005;
    tick();
    host.ioctl_rd = 1'b0;
    chk("drop_err", 32'(rd_err), 32'd1);
    tick();
    chk("drop_din", 32'(host.ioctl_din), 32'hA5);
    tick();

    // Session closes mid-read: read completes, no further RAM access.
    host.ioctl_rd = 1'b1; host.ioctl_addr = 25'h123; exp_q.push_back(8'h79);
    tick();
    host.ioctl_rd = 1'b0; host.ioctl_upload = 1'b0;
    tick();
    chk("selfall_no_mem_rd", 32'(mem_rd), 32'd0);
    tick();
    chk("selfall_din", 32'({busy, host.ioctl_din}), 32'h79);
    tick();
    chk("err_sticky", 32'(rd_err), 32'd1);
    sess_start();
    chk("err_cleared", 32'(rd_err), 32'd0);
    sess_end();

    // OSD opening while dirty requests a save.
    wr_pulse();
    osd_status = 1'b1;
    tick();
    chk("osd_req", 32'(save_req), 32'd1);
    osd_status = 1'b0;
    sess_start();
    chk("req_ack", 32'(save_req), 32'd0);
    tick();
    sess_end();
    tick();
    osd_status = 1'b1;
    tick();
    chk("clean_no_req", 32'(save_req), 32'd0);
    osd_status = 1'b0;
    tick();

    // A write inside the session keeps the image dirty.
    sess_start();
    wr_pulse();
    tick();
    sess_end();
    osd_status = 1'b1;
    tick();
    chk("dirty_kept", 32'(save_req), 32'd1);
    osd_status = 1'b0;

    // Write coinciding with the OSD edge suppresses the request.
    sess_start();
    cpu_wr = 1'b1; osd_status = 1'b1;
    tick();
    cpu_wr = 1'b0;
    chk("wr_wins", 32'(save_req), 32'd0);
    osd_status = 1'b0;

    // Quiet timeout, with a write one cycle early restarting the count.
    wr_pulse();
    repeat (Q - 2) tick();
    wr_pulse();
    seen = 1'b0;
    for (int i = 0; i < Q; i++) begin
      seen = seen | save_req;
      tick();
    end
    chk("quiet_early", 32'(seen | save_req), 32'd0);
    tick();
    chk("quiet_req", 32'(save_req), 32'd1);

    // Leave error/request/data set, then reset in the middle of a read.
    host.ioctl_rd = 1'b1; host.ioctl_addr = 25'h7FF; exp_q.push_back(8'hA5);
    tick();
    host.ioctl_addr = 25'h005;
    tick();
    host.ioctl_rd = 1'b0;
    tick();
    tick();
    chk("pre_reset_state", 32'({rd_err, save_req, host.ioctl_din}), 32'h3A5);
    host.ioctl_rd = 1'b1; host.ioctl_addr = 25'h123;
    tick();
    host.ioctl_rd = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("async_reset", 32'({host.ioctl_din, mem_rd, busy, rd_err, save_req}), 32'd0);
    chk("async_reset_addr", 32'(mem_addr), 32'd0);
    repeat (3) tick();
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | mem_rd | busy;
    end
    chk("no_rd_after_reset", 32'(seen), 32'd0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
